// File: rtl/ma_stage.sv
// Memory-access stage: drives loads/stores over a req/ready handshake and fills the MA/RW latch.
// Optional MA_TIMEOUT_EN adds a BUSY watchdog that aborts a stalled access and sets mem_err_o.
module ma_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        in_valid_i,
  input  logic [31:0] in_pc_i,
  input  logic [31:0] in_alu_result_i,
  input  logic [31:0] in_op2_i,
  input  logic [3:0]  in_rd_i,
  input  logic        in_is_ld_i,
  input  logic        in_is_st_i,
  input  logic        in_is_call_i,
  input  logic        in_is_wb_i,
  output logic        in_stall_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ready_i,
  input  logic [31:0] mem_rdata_i,
  output logic        rw_valid_o,
  output logic [31:0] rw_pc_o,
  output logic [31:0] rw_alu_result_o,
  output logic [31:0] rw_ld_result_o,
  output logic [3:0]  rw_rd_o,
  output logic        rw_is_call_o,
  output logic        rw_is_ld_o,
  output logic        rw_is_wb_o,
  output logic        mem_err_o
);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e      state_q, state_d;
  logic [31:0] hold_pc_q, hold_alu_q, hold_op2_q;
  logic [3:0]  hold_rd_q;
  logic        hold_is_ld_q, hold_is_st_q, hold_is_call_q, hold_is_wb_q;

  logic        rw_valid_q, rw_is_call_q, rw_is_ld_q, rw_is_wb_q;
  logic [31:0] rw_pc_q, rw_alu_q, rw_ld_q;
  logic [3:0]  rw_rd_q;

  logic        hold_load, rw_load, timeout;
  logic [31:0] sel_pc, sel_alu, sel_ld_result;
  logic [3:0]  sel_rd;
  logic        sel_is_ld, sel_is_st, sel_is_call, sel_is_wb;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

`ifdef MA_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            mem_err_q;

  // Counter sits at zero in IDLE, so it is cleared on every entry to BUSY.
  assign cnt_d   = (state_q == StBusy && !mem_ready_i) ? cnt_q + CntW'(1) : '0;
  assign timeout = (state_q == StBusy) && !mem_ready_i &&
                   (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q     <= '0;
      mem_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      mem_err_q <= mem_err_q | timeout;
    end
  end

  assign mem_err_o = mem_err_q;
`else
  assign timeout   = 1'b0;
  assign mem_err_o = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    hold_load = 1'b0;
    rw_load   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (in_valid_i) begin
          if (in_is_ld_i || in_is_st_i) begin
            hold_load = 1'b1;
            state_d   = StBusy;
          end else begin
            rw_load = 1'b1;
          end
        end
      end
      StBusy: begin
        if (mem_ready_i || timeout) begin
          rw_load = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Latch source: live inputs for ALU ops in IDLE, hold registers when finishing a memory op.
  always_comb begin
    sel_pc      = in_pc_i;
    sel_alu     = in_alu_result_i;
    sel_rd      = in_rd_i;
    sel_is_ld   = in_is_ld_i;
    sel_is_st   = in_is_st_i;
    sel_is_call = in_is_call_i;
    sel_is_wb   = in_is_wb_i;
    if (state_q == StBusy) begin
      sel_pc      = hold_pc_q;
      sel_alu     = hold_alu_q;
      sel_rd      = hold_rd_q;
      sel_is_ld   = hold_is_ld_q;
      sel_is_st   = hold_is_st_q;
      sel_is_call = hold_is_call_q;
      sel_is_wb   = hold_is_wb_q;
    end
    // ld+st together is treated as a store.
    if (timeout)                       sel_ld_result = 32'hDEAD_BEEF;
    else if (sel_is_ld && !sel_is_st)  sel_ld_result = mem_rdata_i;
    else                               sel_ld_result = 32'h0;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q        <= StIdle;
      hold_pc_q      <= '0;
      hold_alu_q     <= '0;
      hold_op2_q     <= '0;
      hold_rd_q      <= '0;
      hold_is_ld_q   <= 1'b0;
      hold_is_st_q   <= 1'b0;
      hold_is_call_q <= 1'b0;
      hold_is_wb_q   <= 1'b0;
      rw_valid_q     <= 1'b0;
      rw_pc_q        <= '0;
      rw_alu_q       <= '0;
      rw_ld_q        <= '0;
      rw_rd_q        <= '0;
      rw_is_call_q   <= 1'b0;
      rw_is_ld_q     <= 1'b0;
      rw_is_wb_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rw_valid_q <= rw_load;
      rw_is_wb_q <= rw_load && sel_is_wb && !sel_is_st && !timeout;
      if (hold_load) begin
        hold_pc_q      <= in_pc_i;
        hold_alu_q     <= in_alu_result_i;
        hold_op2_q     <= in_op2_i;
        hold_rd_q      <= in_rd_i;
        hold_is_ld_q   <= in_is_ld_i;
        hold_is_st_q   <= in_is_st_i;
        hold_is_call_q <= in_is_call_i;
        hold_is_wb_q   <= in_is_wb_i;
      end
      if (rw_load) begin
        rw_pc_q      <= sel_pc;
        rw_alu_q     <= sel_alu;
        rw_ld_q      <= sel_ld_result;
        rw_rd_q      <= sel_rd;
        rw_is_call_q <= sel_is_call;
        rw_is_ld_q   <= sel_is_ld && !sel_is_st;
      end
    end
  end

  assign in_stall_o      = (state_q == StBusy);
  assign mem_req_o       = (state_q == StBusy);
  assign mem_we_o        = hold_is_st_q;
  assign mem_addr_o      = hold_alu_q;
  assign mem_wdata_o     = hold_op2_q;
  assign rw_valid_o      = rw_valid_q;
  assign rw_pc_o         = rw_pc_q;
  assign rw_alu_result_o = rw_alu_q;
  assign rw_ld_result_o  = rw_ld_q;
  assign rw_rd_o         = rw_rd_q;
  assign rw_is_call_o    = rw_is_call_q;
  assign rw_is_ld_o      = rw_is_ld_q;
  assign rw_is_wb_o      = rw_is_wb_q;

endmodule

// File: tb/tb_ma_stage.sv
// Randomized bench for ma_stage with a transaction-level reference model.
// Define MA_TIMEOUT_EN on both files to also exercise the BUSY watchdog (TIMEOUT_CYCLES = 4).
module tb_ma_stage;

  localparam int unsigned To = 4;

  logic        clk = 1'b0, reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_pc = '0, in_alu = '0, in_op2 = '0;
  logic [3:0]  in_rd = '0;
  logic        in_is_ld = 1'b0, in_is_st = 1'b0, in_is_call = 1'b0, in_is_wb = 1'b0;
  logic        in_stall, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        rw_valid;
  logic [31:0] rw_pc, rw_alu, rw_ld;
  logic [3:0]  rw_rd;
  logic        rw_is_call, rw_is_ld, rw_is_wb, mem_err;

  ma_stage #(.TIMEOUT_CYCLES(To)) dut (
    .clk_i(clk), .reset_i(reset),
    .in_valid_i(in_valid), .in_pc_i(in_pc), .in_alu_result_i(in_alu), .in_op2_i(in_op2),
    .in_rd_i(in_rd), .in_is_ld_i(in_is_ld), .in_is_st_i(in_is_st),
    .in_is_call_i(in_is_call), .in_is_wb_i(in_is_wb), .in_stall_o(in_stall),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_ready_i(mem_ready), .mem_rdata_i(mem_rdata),
    .rw_valid_o(rw_valid), .rw_pc_o(rw_pc), .rw_alu_result_o(rw_alu), .rw_ld_result_o(rw_ld),
    .rw_rd_o(rw_rd), .rw_is_call_o(rw_is_call), .rw_is_ld_o(rw_is_ld), .rw_is_wb_o(rw_is_wb),
    .mem_err_o(mem_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model of the MA/RW latch contents and the sticky error flag.
  logic [31:0] exp_pc = '0, exp_alu = '0, exp_ld = '0;
  logic [3:0]  exp_rd = '0;
  logic        exp_call = 1'b0, exp_isld = 1'b0, exp_err = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_fields(input string tag);
    check_eq({tag, "_pc"}, rw_pc, exp_pc);
    check_eq({tag, "_alu"}, rw_alu, exp_alu);
    check_eq({tag, "_ld"}, rw_ld, exp_ld);
    check_eq({tag, "_rd"}, {28'h0, rw_rd}, {28'h0, exp_rd});
    check_eq({tag, "_call"}, {31'h0, rw_is_call}, {31'h0, exp_call});
    check_eq({tag, "_isld"}, {31'h0, rw_is_ld}, {31'h0, exp_isld});
    check_eq({tag, "_err"}, {31'h0, mem_err}, {31'h0, exp_err});
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, "_valid"}, {31'h0, rw_valid}, 32'h0);
    check_eq({tag, "_wb"}, {31'h0, rw_is_wb}, 32'h0);
    check_fields(tag);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid  = 1'b0;
      mem_ready = 1'($urandom);
      mem_rdata = $urandom;
      tick();
      mem_ready = 1'b0;
      check_eq("idle_stall", {31'h0, in_stall}, 32'h0);
      check_eq("idle_req", {31'h0, mem_req}, 32'h0);
      check_quiet("idle");
    end
  endtask

  // Issues one instruction starting in an IDLE cycle; returns after its rw_valid pulse.
  task automatic issue(input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] op2,
                       input logic [3:0] rd, input logic ld, input logic st, input logic call,
                       input logic wb, input int wait_n, input logic [31:0] rdata);
    int  busy_n;
    bit  timed_out;
    logic exp_wb;
    check_eq("acc_stall", {31'h0, in_stall}, 32'h0);
    in_valid = 1'b1; in_pc = pc; in_alu = alu; in_op2 = op2; in_rd = rd;
    in_is_ld = ld; in_is_st = st; in_is_call = call; in_is_wb = wb;
    mem_ready = 1'($urandom);
    mem_rdata = $urandom;
    tick();
    in_valid  = 1'b0;
    mem_ready = 1'b0;
    if (!(ld || st)) begin
      exp_pc = pc; exp_alu = alu; exp_ld = 32'h0; exp_rd = rd;
      exp_call = call; exp_isld = 1'b0; exp_wb = wb;
    end else begin
      timed_out = 1'b0;
      busy_n    = wait_n + 1;
`ifdef MA_TIMEOUT_EN
      if (wait_n >= int'(To)) begin
        timed_out = 1'b1;
        busy_n    = int'(To);
      end
`endif
      for (int k = 0; k < busy_n; k++) begin
        check_eq("busy_stall", {31'h0, in_stall}, 32'h1);
        check_eq("busy_req", {31'h0, mem_req}, 32'h1);
        check_eq("busy_addr", mem_addr, alu);
        check_eq("busy_wdata", mem_wdata, op2);
        check_eq("busy_we", {31'h0, mem_we}, {31'h0, st});
        check_quiet("busy");
        // Upstream garbage while stalled must be ignored.
        in_valid = 1'($urandom); in_pc = $urandom; in_alu = $urandom; in_op2 = $urandom;
        in_is_ld = 1'($urandom); in_is_st = 1'($urandom);
        mem_ready = !timed_out && (k == busy_n - 1);
        mem_rdata = mem_ready ? rdata : $urandom;
        tick();
        in_valid  = 1'b0;
        mem_ready = 1'b0;
      end
      exp_pc = pc; exp_alu = alu; exp_rd = rd; exp_call = call;
      exp_isld = ld && !st;
      exp_ld   = timed_out ? 32'hDEAD_BEEF : (ld && !st) ? rdata : 32'h0;
      exp_wb   = wb && !st && !timed_out;
      exp_err  = exp_err | timed_out;
      check_eq("done_stall", {31'h0, in_stall}, 32'h0);
      check_eq("done_req", {31'h0, mem_req}, 32'h0);
    end
    check_eq("pulse_valid", {31'h0, rw_valid}, 32'h1);
    check_eq("pulse_wb", {31'h0, rw_is_wb}, {31'h0, exp_wb});
    check_fields("pulse");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int maxw;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check_eq("rst_stall", {31'h0, in_stall}, 32'h0);
    check_eq("rst_req", {31'h0, mem_req}, 32'h0);
    check_quiet("rst");
    idle(2);

    // ALU op, then a load with 3 wait cycles, then a store with immediate ready.
    issue(32'h0, 32'h10, 32'h0, 4'd3, 1'b0, 1'b0, 1'b0, 1'b1, 0, 32'h0);
    idle(1);
    issue(32'h4, 32'h40, 32'h0, 4'd5, 1'b1, 1'b0, 1'b0, 1'b1, 3, 32'hCAFE_F00D);
    issue(32'h8, 32'h80, 32'h1234, 4'd6, 1'b0, 1'b1, 1'b0, 1'b1, 0, 32'h0);
    // Call immediately followed by a load.
    issue(32'h100, 32'h104, 32'h0, 4'd15, 1'b0, 1'b0, 1'b1, 1'b1, 0, 32'h0);
    issue(32'h104, 32'h44, 32'h0, 4'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1, 32'h5555_AAAA);
    // Illegal ld+st behaves as a store.
    issue(32'h108, 32'h48, 32'h77, 4'd1, 1'b1, 1'b1, 1'b0, 1'b1, 2, 32'hFFFF_FFFF);
    idle(1);

    // Reset in the second BUSY cycle of a load drops the instruction.
    in_valid = 1'b1; in_pc = 32'h200; in_alu = 32'h60; in_rd = 4'd7;
    in_is_ld = 1'b1; in_is_st = 1'b0; in_is_call = 1'b0; in_is_wb = 1'b1;
    tick();
    in_valid = 1'b0;
    check_eq("rb_req1", {31'h0, mem_req}, 32'h1);
    tick();
    check_eq("rb_req2", {31'h0, mem_req}, 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_pc = '0; exp_alu = '0; exp_ld = '0; exp_rd = '0;
    exp_call = 1'b0; exp_isld = 1'b0; exp_err = 1'b0;
    check_eq("rb_req", {31'h0, mem_req}, 32'h0);
    check_eq("rb_stall", {31'h0, in_stall}, 32'h0);
    check_quiet("rb");
    idle(3);

`ifdef MA_TIMEOUT_EN
    maxw = int'(To) - 1;
`else
    maxw = 5;
`endif
    for (int n = 0; n < 40; n++) begin
      int unsigned kind;
      kind = $urandom_range(0, 7);
      issue($urandom, $urandom, $urandom, 4'($urandom), kind inside {[3:4], 7},
            kind inside {[5:7]}, 1'($urandom), 1'($urandom),
            int'($urandom_range(0, maxw)), $urandom);
      if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 2)));
    end

`ifdef MA_TIMEOUT_EN
    issue(32'h300, 32'h90, 32'h0, 4'd9, 1'b1, 1'b0, 1'b0, 1'b1, 100, 32'h0);
    check_eq("to_err", {31'h0, mem_err}, 32'h1);
    issue(32'h304, 32'h94, 32'h0, 4'd9, 1'b1, 1'b0, 1'b0, 1'b1, int'(To) - 1, 32'h1357_9BDF);
    issue(32'h308, 32'h98, 32'h0, 4'd9, 1'b1, 1'b0, 1'b0, 1'b1, 0, 32'h2468_ACE0);
    idle(2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ma_stage.md
# ma_stage

Memory-access stage of the SimpleRisc pipeline. It sits between the execute latch and the writeback stage. It performs loads and stores against the data memory over a req/ready handshake and stalls the upstream stage while a memory operation is in flight. It registers the results (`aluResult`, `ldResult`, `pc`, `rd`, control flags) into the MA/RW latch that the writeback stage consumes.

## Interface
- `TIMEOUT_CYCLES`, 16: number of BUSY cycles without `mem_ready` before abort. Used only with `MA_TIMEOUT_EN`. Minimum 1.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `in_valid` input 1: execute latch holds a valid instruction.
- `in_pc` input 32: instruction PC.
- `in_aluResult` input 32: ALU result; this is the effective address for ld/st.
- `in_op2` input 32: store data.
- `in_rd` input 4: destination register.
- `in_isLd`, `in_isSt`, `in_isCall`, `in_isWb` input 1 each: control flags.
- `in_stall` output 1: upstream must hold its inputs while this is high.
- `mem_req` output 1: memory request.
- `mem_we` output 1: 1 = store, 0 = load.
- `mem_addr` output 32: memory address.
- `mem_wdata` output 32: store data.
- `mem_ready` input 1: memory completes the request in this cycle.
- `mem_rdata` input 32: load data; valid when `mem_ready` is high.
- `rw_valid` output 1: one-cycle pulse; MA/RW latch holds a new instruction.
- `rw_pc`, `rw_aluResult`, `rw_ldResult` output 32 each: MA/RW latch data.
- `rw_rd` output 4: MA/RW latch destination register.
- `rw_isCall`, `rw_isLd`, `rw_isWb` output 1 each: MA/RW latch control flags.
- `mem_err` output 1: sticky timeout flag.

## Operation
- FSM has two states: IDLE and BUSY. Reset puts the FSM in IDLE.
- On reset, every output register is cleared to 0. `in_stall`, `mem_req`, `rw_valid` and `mem_err` are all 0 after reset.
- IDLE with `in_valid` set and neither `in_isLd` nor `in_isSt`:
  - On the next edge, load the MA/RW latch from the inputs and set `rw_ldResult` = 0.
  - `rw_valid` = 1 for one cycle. Stay in IDLE.
- IDLE with `in_valid` set and `in_isLd` or `in_isSt`:
  - Capture all inputs into hold registers and go to BUSY.
- BUSY behaviour:
  - `mem_req` = 1, `in_stall` = 1.
  - `mem_addr` = held `aluResult`, `mem_wdata` = held `op2`, `mem_we` = held `isSt`.
  - These outputs are stable for the whole BUSY interval.
- BUSY with `mem_ready` set:
  - On the next edge, load the MA/RW latch from the hold registers and pulse `rw_valid`.
  - `rw_ldResult` = `mem_rdata` for a load, 0 for a store. Return to IDLE.
- `in_isLd` and `in_isSt` both set is illegal. The block treats it as a store (`mem_we` = 1, `rw_ldResult` = 0).
- Gating of `rw_isWb`:
  - `rw_isWb` is forced to 0 whenever `rw_valid` = 0, so writeback never writes twice.
  - A store never asserts `rw_isWb`.
- When `rw_valid` = 0, the other `rw_*` fields hold their last values.
- `mem_ready` seen while in IDLE is ignored.
- `in_valid` = 0 in IDLE: no state change and no `rw_valid`.

## Timing
- Non-memory instruction: accepted at edge T, `rw_valid` visible after T. Latency is 1 cycle, throughput 1 per cycle.
- Memory instruction:
  - Accepted at edge T. BUSY and `mem_req` start in cycle T+1.
  - With `mem_ready` in the first BUSY cycle, `rw_valid` is seen at T+2. Minimum latency is 2 cycles.
  - Every extra wait cycle adds 1 cycle of latency.
- `in_stall` = 1 in every BUSY cycle, including the cycle in which `mem_ready` is high. The next instruction is accepted on the first IDLE cycle after that.
- `mem_req` deasserts on the edge where `mem_ready` is sampled high. There is no back-to-back request without an intervening IDLE cycle.
- Reset asserted during BUSY: the transaction is abandoned. `mem_req` and `in_stall` are 0 after that edge, and no `rw_valid` is produced for the dropped instruction.

## Configuration
- `MA_TIMEOUT_EN` defined:
  - A counter clears on entry to BUSY and increments each BUSY cycle without `mem_ready`.
  - When the count reaches `TIMEOUT_CYCLES`, the access completes as if `mem_ready` had arrived.
  - On timeout, `rw_ldResult` = 32'hDEADBEEF and `rw_isWb` = 0. `mem_err` is set and stays high until reset.
  - If `mem_ready` arrives in the same cycle the count reaches the limit, it wins: normal completion, no error.
- `MA_TIMEOUT_EN` undefined: there is no counter, BUSY waits indefinitely, and `mem_err` is tied to 0.

## Test plan
- Reset, then an ALU instruction (`in_aluResult` = 32'h10, `in_rd` = 3, `in_isWb` = 1) -> one cycle later `rw_valid` = 1, `rw_aluResult` = 32'h10, `rw_rd` = 3, `rw_isWb` = 1, `rw_ldResult` = 0; `in_stall` never rises.
- Load from address 32'h40 with `mem_ready` after 3 wait cycles and `mem_rdata` = 32'hCAFEF00D -> `mem_req` is held for 4 cycles with `mem_addr` = 32'h40 and `mem_we` = 0; `rw_ldResult` = 32'hCAFEF00D, `rw_isLd` = 1; `in_stall` is high 4 cycles.
- Store of `in_op2` = 32'h1234 to 32'h80 with immediate `mem_ready` -> `mem_we` = 1, `mem_wdata` = 32'h1234; `rw_valid` appears 2 cycles after acceptance with `rw_isWb` = 0.
- Call (`in_isCall` = 1, `in_pc` = 32'h100) immediately followed by a load -> `rw_isCall` = 1 and `rw_pc` = 32'h100 on the first pulse; the load is accepted the next cycle with no lost or duplicated `rw_valid`.
- `reset` asserted in the second BUSY cycle of a load -> `mem_req` = 0 and `in_stall` = 0 after that edge; no `rw_valid` follows.
- With `MA_TIMEOUT_EN` and `TIMEOUT_CYCLES` = 4, a load with `mem_ready` held low -> after 4 BUSY cycles `rw_ldResult` = 32'hDEADBEEF, `rw_isWb` = 0, `mem_err` = 1, and it stays set after later good accesses.
